// File: rtl/sseg_pkg.sv
// Shared 7-segment definitions used by both the hex-to-segment encoder and the
// scan decoder, so the two ends of the display path agree on a single table.
// Contents: segment pattern constants (a=bit6 .. g=bit0, active-low), blank
// pattern, drive polarity, scan FSM state type and an encode helper.
package sseg_pkg;

   // Anodes and segments are both driven low to light.
   localparam logic ACTIVE_LOW_ON = 1'b0;

   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b1100000;
   localparam logic [6:0] SEG_C     = 7'b0110001;
   localparam logic [6:0] SEG_D     = 7'b1000010;
   localparam logic [6:0] SEG_E     = 7'b0110000;
   localparam logic [6:0] SEG_F     = 7'b0111000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {
      ST_WAIT,
      ST_STABLE,
      ST_SAMPLED
   } scan_state_e;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = SEG_A;
         4'hB: seg = SEG_B;
         4'hC: seg = SEG_C;
         4'hD: seg = SEG_D;
         4'hE: seg = SEG_E;
         default: seg = SEG_F;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/sseg_scan_decoder_seg7_to_hex.sv
// Combinational 7-segment pattern to hex nibble decoder.
// Ports: seg   - active-low segment pattern, a=bit6 .. g=bit0
//        legal - pattern is one of the 16 hex glyphs
//        nib   - decoded value (0 when illegal)
module seg7_to_hex
   import sseg_pkg::*;
(
   input  logic [6:0] seg,
   output logic       legal,
   output logic [3:0] nib
);

   always_comb begin
      legal = 1'b1;
      nib   = 4'h0;
      case (seg)
         SEG_0: nib = 4'h0;
         SEG_1: nib = 4'h1;
         SEG_2: nib = 4'h2;
         SEG_3: nib = 4'h3;
         SEG_4: nib = 4'h4;
         SEG_5: nib = 4'h5;
         SEG_6: nib = 4'h6;
         SEG_7: nib = 4'h7;
         SEG_8: nib = 4'h8;
         SEG_9: nib = 4'h9;
         SEG_A: nib = 4'hA;
         SEG_B: nib = 4'hB;
         SEG_C: nib = 4'hC;
         SEG_D: nib = 4'hD;
         SEG_E: nib = 4'hE;
         SEG_F: nib = 4'hF;
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/sseg_scan_decoder.sv
// Loopback monitor for a multiplexed N-digit 7-segment display bus. Waits for
// each anode/segment dwell to settle, takes one sample per dwell, and commits a
// digit once MATCH consecutive samples of it agree.
// Ports: clk, reset (async, active-high)
//        an    - anode enables, active-low, bit i = digit i
//        sseg  - [7]=dp, [6:0]=a..g, active-low
//        hex   - committed digits, digit i at [4i+3:4i]
//        dp    - committed decimal points, 1 = lit
//        valid - every digit committed at least once since reset
//        upd   - 1-cycle pulse when a commit changed hex/dp
//        err   - 1-cycle pulse on illegal pattern or multiple anodes low
module sseg_scan_decoder
   import sseg_pkg::*;
#(
   parameter int unsigned N_DIG  = 4,
   parameter int unsigned SETTLE = 4,
   parameter int unsigned MATCH  = 2
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_DIG-1:0]     an,
   input  logic [7:0]           sseg,
   output logic [4*N_DIG-1:0]   hex,
   output logic [N_DIG-1:0]     dp,
   output logic                 valid,
   output logic                 upd,
   output logic                 err
);

   localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam int unsigned MW = $clog2(MATCH + 1);
   localparam int unsigned IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
   localparam logic [CW-1:0] CNT_MAX  = CW'(SETTLE - 1);
   localparam logic [MW-1:0] MCNT_MAX = MW'(MATCH);

   logic [N_DIG+7:0]         in_q, in_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   scan_state_e              state_q, state_d;
   logic [N_DIG-1:0][4:0]    cand_q, cand_d;
   logic [N_DIG-1:0][MW-1:0] mcnt_q, mcnt_d;
   logic [N_DIG-1:0][3:0]    hex_q, hex_d;
   logic [N_DIG-1:0]         dp_q, dp_d;
   logic [N_DIG-1:0]         committed_q, committed_d;
   logic                     valid_q, valid_d;
   logic                     upd_q, upd_d;
   logic                     err_q, err_d;

   logic                     changed;
   logic [N_DIG-1:0]         s_an;
   logic [7:0]               s_seg;
   logic                     seg_legal;
   logic [3:0]               seg_nib;
   int unsigned              n_low;
   logic [IW-1:0]            low_idx;
   logic [4:0]               smp;
   logic [MW-1:0]            m_new;

   // Samples are taken from the registered copy, which is the value that
   // was held unchanged for the whole settle window.
   assign s_an  = in_q[N_DIG+7:8];
   assign s_seg = in_q[7:0];

   seg7_to_hex u_dec (
      .seg   (s_seg[6:0]),
      .legal (seg_legal),
      .nib   (seg_nib)
   );

   always_comb begin
      in_d    = {an, sseg};
      changed = (in_d != in_q);
      if (changed)
         cnt_d = '0;
      else if (cnt_q != CNT_MAX)
         cnt_d = cnt_q + 1'b1;
      else
         cnt_d = cnt_q;

      // The first branch also covers SETTLE=1, where a change itself
      // completes the settle window.
      if (cnt_d == CNT_MAX && (changed || state_q == ST_WAIT))
         state_d = ST_STABLE;
      else if (changed)
         state_d = ST_WAIT;
      else if (state_q == ST_STABLE)
         state_d = ST_SAMPLED;
      else
         state_d = state_q;
   end

   always_comb begin
      n_low   = 0;
      low_idx = '0;
      for (int unsigned i = 0; i < N_DIG; i++) begin
         if (s_an[i] == ACTIVE_LOW_ON) begin
            n_low   = n_low + 1;
            low_idx = IW'(i);
         end
      end

      smp         = {s_seg[7] == ACTIVE_LOW_ON, seg_nib};
      m_new       = '0;
      cand_d      = cand_q;
      mcnt_d      = mcnt_q;
      hex_d       = hex_q;
      dp_d        = dp_q;
      committed_d = committed_q;
      upd_d       = 1'b0;
      err_d       = 1'b0;

      if (state_q == ST_STABLE) begin
         if (n_low > 1) begin
            err_d = 1'b1;
         end else if (n_low == 1) begin
            if (!seg_legal) begin
               err_d           = 1'b1;
               mcnt_d[low_idx] = '0;
            end else begin
               if (smp == cand_q[low_idx])
                  m_new = (mcnt_q[low_idx] == MCNT_MAX) ? MCNT_MAX : mcnt_q[low_idx] + 1'b1;
               else
                  m_new = MW'(1);
               cand_d[low_idx] = smp;
               mcnt_d[low_idx] = m_new;
               if (m_new == MCNT_MAX) begin
                  hex_d[low_idx]       = smp[3:0];
                  dp_d[low_idx]        = smp[4];
                  committed_d[low_idx] = 1'b1;
                  upd_d = (smp != {dp_q[low_idx], hex_q[low_idx]});
               end
            end
         end
      end

      valid_d = &committed_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_q        <= '1;
         cnt_q       <= '0;
         state_q     <= ST_WAIT;
         cand_q      <= '0;
         mcnt_q      <= '0;
         hex_q       <= '0;
         dp_q        <= '0;
         committed_q <= '0;
         valid_q     <= 1'b0;
         upd_q       <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         in_q        <= in_d;
         cnt_q       <= cnt_d;
         state_q     <= state_d;
         cand_q      <= cand_d;
         mcnt_q      <= mcnt_d;
         hex_q       <= hex_d;
         dp_q        <= dp_d;
         committed_q <= committed_d;
         valid_q     <= valid_d;
         upd_q       <= upd_d;
         err_q       <= err_d;
      end
   end

   assign hex   = hex_q;
   assign dp    = dp_q;
   assign valid = valid_q;
   assign upd   = upd_q;
   assign err   = err_q;

endmodule

// File: tb/tb_sseg_scan_decoder.sv
module tb_sseg_scan_decoder;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  an;
   logic [7:0]  sseg;
   logic [15:0] hex;
   logic [3:0]  dp;
   logic        valid, upd, err;

   int n_cmp   = 0;
   int n_bad   = 0;
   int upd_cnt = 0;
   int err_cnt = 0;

   localparam logic [6:0] P_1   = 7'b1001111;
   localparam logic [6:0] P_2   = 7'b0010010;
   localparam logic [6:0] P_3   = 7'b0000110;
   localparam logic [6:0] P_5   = 7'b0100100;
   localparam logic [6:0] P_7   = 7'b0001111;
   localparam logic [6:0] P_8   = 7'b0000000;
   localparam logic [6:0] P_A   = 7'b0001000;
   localparam logic [6:0] P_F   = 7'b0111000;
   localparam logic [6:0] P_BAD = 7'b1111110;
   localparam logic [6:0] P_OFF = 7'b1111111;

   localparam logic [3:0] D0 = 4'b1110;
   localparam logic [3:0] D1 = 4'b1101;
   localparam logic [3:0] D2 = 4'b1011;
   localparam logic [3:0] D3 = 4'b0111;
   localparam logic [3:0] DN = 4'b1111;

   always #5 clk = ~clk;

   sseg_scan_decoder #(
      .N_DIG  (4),
      .SETTLE (4),
      .MATCH  (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .an    (an),
      .sseg  (sseg),
      .hex   (hex),
      .dp    (dp),
      .valid (valid),
      .upd   (upd),
      .err   (err)
   );

   // Pulse counters: one count per clock cycle the pulse is high.
   always @(negedge clk) begin
      if (upd === 1'b1) upd_cnt++;
      if (err === 1'b1) err_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive one dwell starting at a falling edge; returns on a falling edge.
   task automatic show(input logic [3:0] a, input logic [6:0] s, input logic dp_lit,
                       input int cyc);
      an   = a;
      sseg = {~dp_lit, s};
      repeat (cyc) @(negedge clk);
   endtask

   logic [3:0] an_tab [4];
   logic [6:0] pat_tab[4];
   int u0, e0;

   initial begin
      an_tab  = '{D0, D1, D2, D3};
      pat_tab = '{P_F, P_3, P_A, P_1};

      reset = 1'b1;
      an    = DN;
      sseg  = 8'hFF;
      repeat (3) @(negedge clk);
      chk("rst_hex",   32'(hex),   32'h0);
      chk("rst_dp",    32'(dp),    32'h0);
      chk("rst_valid", 32'(valid), 32'h0);
      chk("rst_upd",   32'(upd),   32'h0);
      chk("rst_err",   32'(err),   32'h0);
      reset = 1'b0;
      show(DN, P_OFF, 1'b0, 4);

      // Static scan "1A3F", two passes
      for (int s = 0; s < 2; s++) begin
         for (int d = 0; d < 4; d++) begin
            show(an_tab[d], pat_tab[d], 1'b0, 8);
            if (s == 1) chk("scan_valid", 32'(valid), (d == 3) ? 32'h1 : 32'h0);
         end
         if (s == 0) begin
            chk("scan1_hex", 32'(hex), 32'h0);
            chk("scan1_upd", 32'(upd_cnt), 32'd0);
         end
      end
      chk("scan_hex", 32'(hex),     32'h1A3F);
      chk("scan_dp",  32'(dp),      32'h0);
      chk("scan_upd", 32'(upd_cnt), 32'd4);
      chk("scan_err", 32'(err_cnt), 32'd0);

      // Glitch shorter than the settle window is ignored
      show(D0, P_3, 1'b0, 3);
      show(DN, P_OFF, 1'b0, 8);
      chk("glitch_hex", 32'(hex),     32'h1A3F);
      chk("glitch_err", 32'(err_cnt), 32'd0);
      show(D0, P_3, 1'b0, 8);
      show(DN, P_OFF, 1'b0, 8);
      chk("glitch_one_sample_hex", 32'(hex),     32'h1A3F);
      chk("glitch_upd",            32'(upd_cnt), 32'd4);

      // Illegal pattern on digit 2, then two legal '7' dwells
      show(D2, P_BAD, 1'b0, 8);
      chk("illegal_err", 32'(err_cnt), 32'd1);
      chk("illegal_hex", 32'(hex),     32'h1A3F);
      show(D2, P_7, 1'b0, 8);
      show(DN, P_OFF, 1'b0, 8);
      chk("seven_once_hex", 32'(hex), 32'h1A3F);
      show(D2, P_7, 1'b0, 8);
      chk("seven_hex", 32'(hex),     32'h173F);
      chk("seven_upd", 32'(upd_cnt), 32'd5);
      chk("seven_err", 32'(err_cnt), 32'd1);

      // Two anodes low
      show(4'b1100, P_8, 1'b0, 8);
      chk("multi_err", 32'(err_cnt), 32'd2);
      show(DN, P_8, 1'b0, 8);
      chk("blank_no_err", 32'(err_cnt), 32'd2);
      show(4'b1100, P_8, 1'b0, 8);
      show(DN, P_8, 1'b0, 8);
      chk("multi_err2", 32'(err_cnt), 32'd3);
      chk("multi_hex",  32'(hex),     32'h173F);
      chk("multi_upd",  32'(upd_cnt), 32'd5);

      // Digit 1 to '5', then decimal point only
      show(D1, P_5, 1'b0, 8);
      show(DN, P_OFF, 1'b0, 8);
      show(D1, P_5, 1'b0, 8);
      chk("five_hex", 32'(hex),     32'h175F);
      chk("five_dp",  32'(dp),      32'h0);
      chk("five_upd", 32'(upd_cnt), 32'd6);
      show(DN, P_OFF, 1'b0, 8);
      show(D1, P_5, 1'b1, 8);
      show(DN, P_OFF, 1'b0, 8);
      show(D1, P_5, 1'b1, 8);
      chk("dp_dp",  32'(dp),      32'h2);
      chk("dp_hex", 32'(hex),     32'h175F);
      chk("dp_upd", 32'(upd_cnt), 32'd7);
      show(DN, P_OFF, 1'b0, 8);
      show(D1, P_5, 1'b1, 8);
      show(DN, P_OFF, 1'b0, 8);
      show(D1, P_5, 1'b1, 8);
      chk("same_upd", 32'(upd_cnt), 32'd7);
      chk("same_dp",  32'(dp),      32'h2);

      // Reset mid-dwell with digits committed
      show(D0, P_2, 1'b0, 3);
      u0    = upd_cnt;
      e0    = err_cnt;
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_hex",   32'(hex),   32'h0);
      chk("mid_rst_dp",    32'(dp),    32'h0);
      chk("mid_rst_valid", 32'(valid), 32'h0);
      repeat (3) @(negedge clk);
      chk("mid_rst_upd", 32'(upd_cnt), 32'(u0));
      chk("mid_rst_err", 32'(err_cnt), 32'(e0));
      reset = 1'b0;
      show(D0, P_2, 1'b0, 8);
      chk("post_rst_one_hex", 32'(hex), 32'h0);
      show(DN, P_OFF, 1'b0, 8);
      show(D0, P_2, 1'b0, 8);
      chk("post_rst_hex",   32'(hex),   32'h0002);
      chk("post_rst_valid", 32'(valid), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
